ps2_direction_decoder: RTL and testbench
========================================

// Module: ps2_direction_decoder
// PURPOSE
//  Receives PS/2 keyboard frames and decodes key make-codes into the 3-bit direction word
//  consumed by the snake game core. Keys: W/A/S/D, arrow keys, and Space (game reset).
//  Sits upstream of the game core. Output holds the last accepted command between key presses.
// PARAMETERS
//  FILTER_LEN     8      consecutive equal samples required to change filtered ps2_clk
//  TIMEOUT_CYCLES 40000  clk cycles without a falling edge mid-frame before abort (1 ms @ 40 MHz)
//  ALLOW_REVERSE  0      1: accept 180-degree reversals; 0: reject them
// PORTS
//  clk        in   1  system/pixel clock
//  rst_n      in   1  asynchronous reset, active low
//  ps2_clk    in   1  raw PS/2 clock (asynchronous, open-collector)
//  ps2_data   in   1  raw PS/2 data (asynchronous)
//  direction  out  3  d=000 s=001 a=010 w=011 rst=100
//  key_valid  out  1  one-cycle pulse when a command is accepted
//  frame_err  out  1  one-cycle pulse on parity/start/stop error or timeout
//  scan_code  out  8  last correctly framed byte (debug)
// BEHAVIOUR
//  Reset values: direction=100 (rst), key_valid=0, frame_err=0, scan_code=00.
//   FSM=IDLE; brk and ext flags cleared. Reset mid-frame discards the partial frame.
//  Input path: 2-FF synchroniser on each of ps2_clk and ps2_data.
//   Filtered clock starts at 1 and changes only after FILTER_LEN equal consecutive synced samples.
//   Event fe = filtered clock 1->0. Data is sampled on fe.
//  Frame FSM (advances on fe only):
//   IDLE   -> DATA if data=0; stays IDLE if data=1 (no error)
//   DATA   8 bits, LSB first; -> PARITY after bit 7
//   PARITY odd parity over 8 data bits + parity bit
//   STOP   data must be 1 -> IDLE; byte_rdy if parity ok, else frame_err
//  Timeout: counter clears on every fe and while in IDLE. Any non-IDLE state reaching
//   TIMEOUT_CYCLES -> IDLE, frame_err pulse, byte discarded.
//  Latency: fe sampling stop bit at cycle N -> byte_rdy/scan_code at N+1 -> direction/key_valid at N+2.
//  Byte decoder (on byte_rdy):
//   E0 sets ext; F0 sets brk.
//   Any other byte with brk=1 is a break code: ignored, both flags cleared.
//   Otherwise it is a make code, looked up with ext, then both flags cleared:
//    ext=0: 1D->w 1C->a 1B->s 23->d 29->rst
//    ext=1: 75->w 6B->a 72->s 74->d
//   Unrecognised code: ignored, flags cleared, no pulse.
//  Acceptance rules:
//   rst is always accepted.
//   Any direction is accepted when current direction is rst.
//   With ALLOW_REVERSE=0, w<->s and a<->d reversals are rejected: no change, no key_valid.
//   Repeat of the current direction (typematic) is accepted; key_valid pulses, value unchanged.
//  key_valid and frame_err never assert in the same cycle. frame_err does not alter direction.
// TESTING
//  1 Reset -> direction=100, outputs 0. Frame 1D (bits 1,0,1,1,1,0,0,0; par=1; stop=1)
//    -> scan_code=1D, direction=011, key_valid single pulse 2 clk after stop edge.
//  2 From w, send 1B (S) -> direction stays 011, no key_valid.
//    Repeat with ALLOW_REVERSE=1 -> direction=001.
//  3 Send F0 then 1C -> direction unchanged, no pulse.
//    Then E0 6B -> direction=010, one key_valid.
//  4 Frame 1D with parity=0 -> frame_err pulse, direction and scan_code unchanged.
//    Frame with stop=0 -> frame_err pulse.
//  5 Stop ps2_clk after 4 data bits -> frame_err pulse at TIMEOUT_CYCLES.
//    Next full 23 frame decodes correctly.
//  6 Glitch on ps2_clk low for FILTER_LEN-1 cycles -> no bit sampled.
//    rst_n low mid-frame -> direction=100; next 29 frame -> key_valid, direction=100.

Source files
------------

// File: rtl/ps2_direction_decoder.sv
module ps2_direction_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 40000,
  parameter int unsigned ALLOW_REVERSE  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] direction,
  output logic       key_valid,
  output logic       frame_err,
  output logic [7:0] scan_code
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  typedef enum logic [2:0] {
    DIR_D   = 3'b000,
    DIR_S   = 3'b001,
    DIR_A   = 3'b010,
    DIR_W   = 3'b011,
    DIR_RST = 3'b100
  } dir_e;

  // input synchronisers
  logic clk_meta_q, clk_sync_q;
  logic data_meta_q, data_sync_q;

  // clock filter
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fe_q, fe_d;

  // frame receiver
  frame_state_e  state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          byte_rdy_q, byte_rdy_d;
  logic          ferr_q, ferr_d;
  logic [7:0]    scan_q, scan_d;

  // byte decoder
  logic brk_q, brk_d;
  logic ext_q, ext_d;
  dir_e dir_q, dir_d;
  logic kv_q, kv_d;
  dir_e cmd;
  logic cmd_ok;
  logic reversal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  // The counter tracks consecutive samples that disagree with the filtered
  // level; the level flips on the FILTER_LEN-th such sample.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fe_d       = 1'b0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
        fe_d   = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      fe_q       <= 1'b0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      fe_q       <= fe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    to_cnt_d   = '0;
    byte_rdy_d = 1'b0;
    ferr_d     = 1'b0;
    scan_d     = scan_q;
    if (fe_q) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!data_sync_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_d   = data_sync_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (data_sync_q && (^{shift_q, par_q})) begin
            byte_rdy_d = 1'b1;
            scan_d     = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_IDLE;
        ferr_d  = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      byte_rdy_q <= 1'b0;
      ferr_q     <= 1'b0;
      scan_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      byte_rdy_q <= byte_rdy_d;
      ferr_q     <= ferr_d;
      scan_q     <= scan_d;
    end
  end

  always_comb begin
    cmd    = DIR_RST;
    cmd_ok = 1'b1;
    unique case ({ext_q, scan_q})
      9'h01D:  cmd = DIR_W;
      9'h01C:  cmd = DIR_A;
      9'h01B:  cmd = DIR_S;
      9'h023:  cmd = DIR_D;
      9'h029:  cmd = DIR_RST;
      9'h175:  cmd = DIR_W;
      9'h16B:  cmd = DIR_A;
      9'h172:  cmd = DIR_S;
      9'h174:  cmd = DIR_D;
      default: cmd_ok = 1'b0;
    endcase
  end

  // w/s and a/d differ only in bit 1, so a reversal is an xor of 3'b010
  // between two non-rst codes.
  assign reversal = (cmd != DIR_RST) && (dir_q != DIR_RST) &&
                    ((cmd ^ dir_q) == 3'b010);

  always_comb begin
    dir_d = dir_q;
    kv_d  = 1'b0;
    brk_d = brk_q;
    ext_d = ext_q;
    if (byte_rdy_q) begin
      if (scan_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (scan_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!brk_q && cmd_ok && ((ALLOW_REVERSE != 0) || !reversal)) begin
          dir_d = cmd;
          kv_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_q <= 1'b0;
      ext_q <= 1'b0;
      dir_q <= DIR_RST;
      kv_q  <= 1'b0;
    end else begin
      brk_q <= brk_d;
      ext_q <= ext_d;
      dir_q <= dir_d;
      kv_q  <= kv_d;
    end
  end

  assign direction = dir_q;
  assign key_valid = kv_q;
  assign frame_err = ferr_q;
  assign scan_code = scan_q;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
module tb_ps2_direction_decoder;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 300;
  localparam int unsigned HALF = 20;

  localparam logic [2:0] C_D = 3'b000;
  localparam logic [2:0] C_S = 3'b001;
  localparam logic [2:0] C_A = 3'b010;
  localparam logic [2:0] C_W = 3'b011;
  localparam logic [2:0] C_R = 3'b100;

  typedef struct {
    int         kind;   // 1 = key_valid, 2 = frame_err
    logic [2:0] dir;
    logic [7:0] scan;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [2:0] dir [2];
  logic       kv [2];
  logic       fe [2];
  logic [7:0] sc [2];

  ev_t exp_q [2][$];
  ev_t got_q [2][$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int coll = 0;
  int last_fall = 0;

  logic [2:0] m_dir [2];
  logic       m_brk, m_ext;
  logic [7:0] m_scan;

  ps2_direction_decoder #(
    .FILTER_LEN(FL),
    .TIMEOUT_CYCLES(TO),
    .ALLOW_REVERSE(0)
  ) u_norev (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .direction(dir[0]), .key_valid(kv[0]), .frame_err(fe[0]), .scan_code(sc[0])
  );

  ps2_direction_decoder #(
    .FILTER_LEN(FL),
    .TIMEOUT_CYCLES(TO),
    .ALLOW_REVERSE(1)
  ) u_rev (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .direction(dir[1]), .key_valid(kv[1]), .frame_err(fe[1]), .scan_code(sc[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int unsigned u = 0; u < 2; u++) begin
      if (kv[u] === 1'b1) got_q[u].push_back('{kind: 1, dir: dir[u], scan: sc[u], cyc: cyc});
      if (fe[u] === 1'b1) got_q[u].push_back('{kind: 2, dir: dir[u], scan: sc[u], cyc: cyc});
      if (kv[u] === 1'b1 && fe[u] === 1'b1) coll = coll + 1;
    end
  end

  task automatic model_byte(input logic [7:0] b);
    logic [2:0] cmd;
    logic       ok;
    logic       rev;
    m_scan = b;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      ok = 1'b1;
      cmd = C_R;
      case ({m_ext, b})
        9'h01D: cmd = C_W;
        9'h01C: cmd = C_A;
        9'h01B: cmd = C_S;
        9'h023: cmd = C_D;
        9'h029: cmd = C_R;
        9'h175: cmd = C_W;
        9'h16B: cmd = C_A;
        9'h172: cmd = C_S;
        9'h174: cmd = C_D;
        default: ok = 1'b0;
      endcase
      if (!m_brk && ok) begin
        for (int unsigned u = 0; u < 2; u++) begin
          rev = (m_dir[u] == C_W && cmd == C_S) || (m_dir[u] == C_S && cmd == C_W) ||
                (m_dir[u] == C_A && cmd == C_D) || (m_dir[u] == C_D && cmd == C_A);
          if (cmd == C_R || m_dir[u] == C_R || u == 1 || !rev) begin
            m_dir[u] = cmd;
            exp_q[u].push_back('{kind: 1, dir: cmd, scan: b, cyc: 0});
          end
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic model_err();
    for (int unsigned u = 0; u < 2; u++)
      exp_q[u].push_back('{kind: 2, dir: m_dir[u], scan: m_scan, cyc: 0});
  endtask

  task automatic ps2_bit(input logic v);
    @(negedge clk);
    ps2_data = v;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop,
                            input int unsigned nbits);
    logic [10:0] f;
    f = {stop, (~^b) ^ bad_par, b, 1'b0};
    if (nbits == 11 && !bad_par && stop) model_byte(b);
    else model_err();
    for (int unsigned i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    for (int unsigned u = 0; u < 2; u++) begin
      n_cmp++;
      if (dir[u] !== C_R || kv[u] !== 1'b0 || fe[u] !== 1'b0 || sc[u] !== 8'h00) begin
        n_bad++;
        $display("FAIL reset u%0d: dir=%b kv=%b fe=%b sc=%h, required dir=100 kv=0 fe=0 sc=00",
                 u, dir[u], kv[u], fe[u], sc[u]);
      end
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_make();
    ev_t e, g;
    send_frame(8'h1D, 0, 1, 11);
    n_cmp++;
    if (got_q[0].size() == 0) begin
      n_bad++;
      $display("FAIL make_latency: no key_valid seen, required one at +%0d", FL + 4);
    end else if (got_q[0][0].cyc - last_fall !== FL + 4) begin
      n_bad++;
      $display("FAIL make_latency: key_valid at +%0d, required +%0d",
               got_q[0][0].cyc - last_fall, FL + 4);
    end
    n_cmp++;
    if (sc[0] !== 8'h1D) begin
      n_bad++;
      $display("FAIL make_scan: scan_code=%h, required 1d", sc[0]);
    end
    for (int unsigned u = 0; u < 2; u++) begin
      while (exp_q[u].size() > 0 || got_q[u].size() > 0) begin
        n_cmp++;
        if (exp_q[u].size() == 0) begin
          g = got_q[u].pop_front(); n_bad++;
          $display("FAIL make u%0d: extra event kind=%0d dir=%b, required none", u, g.kind, g.dir);
        end else if (got_q[u].size() == 0) begin
          e = exp_q[u].pop_front(); n_bad++;
          $display("FAIL make u%0d: no event, required kind=%0d dir=%b", u, e.kind, e.dir);
        end else begin
          e = exp_q[u].pop_front(); g = got_q[u].pop_front();
          if (g.kind !== e.kind || g.dir !== e.dir || g.scan !== e.scan) begin
            n_bad++;
            $display("FAIL make u%0d: kind=%0d dir=%b sc=%h, required kind=%0d dir=%b sc=%h",
                     u, g.kind, g.dir, g.scan, e.kind, e.dir, e.scan);
          end
        end
      end
    end
  endtask

  task automatic test_reverse();
    ev_t e, g;
    send_frame(8'h1B, 0, 1, 11);
    for (int unsigned u = 0; u < 2; u++) begin
      while (exp_q[u].size() > 0 || got_q[u].size() > 0) begin
        n_cmp++;
        if (exp_q[u].size() == 0) begin
          g = got_q[u].pop_front(); n_bad++;
          $display("FAIL reverse u%0d: extra event kind=%0d dir=%b, required none", u, g.kind, g.dir);
        end else if (got_q[u].size() == 0) begin
          e = exp_q[u].pop_front(); n_bad++;
          $display("FAIL reverse u%0d: no event, required kind=%0d dir=%b", u, e.kind, e.dir);
        end else begin
          e = exp_q[u].pop_front(); g = got_q[u].pop_front();
          if (g.kind !== e.kind || g.dir !== e.dir || g.scan !== e.scan) begin
            n_bad++;
            $display("FAIL reverse u%0d: kind=%0d dir=%b sc=%h, required kind=%0d dir=%b sc=%h",
                     u, g.kind, g.dir, g.scan, e.kind, e.dir, e.scan);
          end
        end
      end
    end
    n_cmp++;
    if (dir[0] !== C_W || dir[1] !== C_S) begin
      n_bad++;
      $display("FAIL reverse_dir: norev=%b rev=%b, required 011 and 001", dir[0], dir[1]);
    end
  endtask

  task automatic test_break_ext();
    ev_t e, g;
    send_frame(8'hF0, 0, 1, 11);
    send_frame(8'h1C, 0, 1, 11);
    send_frame(8'hE0, 0, 1, 11);
    send_frame(8'h6B, 0, 1, 11);
    for (int unsigned u = 0; u < 2; u++) begin
      while (exp_q[u].size() > 0 || got_q[u].size() > 0) begin
        n_cmp++;
        if (exp_q[u].size() == 0) begin
          g = got_q[u].pop_front(); n_bad++;
          $display("FAIL break_ext u%0d: extra event kind=%0d dir=%b, required none", u, g.kind, g.dir);
        end else if (got_q[u].size() == 0) begin
          e = exp_q[u].pop_front(); n_bad++;
          $display("FAIL break_ext u%0d: no event, required kind=%0d dir=%b", u, e.kind, e.dir);
        end else begin
          e = exp_q[u].pop_front(); g = got_q[u].pop_front();
          if (g.kind !== e.kind || g.dir !== e.dir || g.scan !== e.scan) begin
            n_bad++;
            $display("FAIL break_ext u%0d: kind=%0d dir=%b sc=%h, required kind=%0d dir=%b sc=%h",
                     u, g.kind, g.dir, g.scan, e.kind, e.dir, e.scan);
          end
        end
      end
    end
    n_cmp++;
    if (dir[0] !== C_A || dir[1] !== C_A) begin
      n_bad++;
      $display("FAIL break_ext_dir: %b %b, required 010 010", dir[0], dir[1]);
    end
  endtask

  task automatic test_frame_errors();
    ev_t e, g;
    send_frame(8'h1D, 1, 1, 11);
    send_frame(8'h1D, 0, 0, 11);
    for (int unsigned u = 0; u < 2; u++) begin
      while (exp_q[u].size() > 0 || got_q[u].size() > 0) begin
        n_cmp++;
        if (exp_q[u].size() == 0) begin
          g = got_q[u].pop_front(); n_bad++;
          $display("FAIL frame_err u%0d: extra event kind=%0d dir=%b, required none", u, g.kind, g.dir);
        end else if (got_q[u].size() == 0) begin
          e = exp_q[u].pop_front(); n_bad++;
          $display("FAIL frame_err u%0d: no event, required kind=%0d dir=%b", u, e.kind, e.dir);
        end else begin
          e = exp_q[u].pop_front(); g = got_q[u].pop_front();
          if (g.kind !== e.kind || g.dir !== e.dir || g.scan !== e.scan) begin
            n_bad++;
            $display("FAIL frame_err u%0d: kind=%0d dir=%b sc=%h, required kind=%0d dir=%b sc=%h",
                     u, g.kind, g.dir, g.scan, e.kind, e.dir, e.scan);
          end
        end
      end
    end
    n_cmp++;
    if (sc[0] !== 8'h6B || dir[0] !== C_A) begin
      n_bad++;
      $display("FAIL frame_err_hold: sc=%h dir=%b, required 6b 010", sc[0], dir[0]);
    end
  endtask

  task automatic test_timeout();
    ev_t e, g;
    int  dt;
    send_frame(8'h55, 0, 1, 5);
    repeat (TO + 40) @(negedge clk);
    n_cmp++;
    if (got_q[0].size() == 0) begin
      n_bad++;
      $display("FAIL timeout_lat: no frame_err within bound, required one near +%0d", TO);
    end else begin
      dt = got_q[0][0].cyc - last_fall;
      if (dt < int'(TO) || dt > int'(TO + FL + 6)) begin
        n_bad++;
        $display("FAIL timeout_lat: frame_err at +%0d, required within [%0d,%0d]", dt, TO, TO + FL + 6);
      end
    end
    send_frame(8'h23, 0, 1, 11);
    for (int unsigned u = 0; u < 2; u++) begin
      while (exp_q[u].size() > 0 || got_q[u].size() > 0) begin
        n_cmp++;
        if (exp_q[u].size() == 0) begin
          g = got_q[u].pop_front(); n_bad++;
          $display("FAIL timeout u%0d: extra event kind=%0d dir=%b, required none", u, g.kind, g.dir);
        end else if (got_q[u].size() == 0) begin
          e = exp_q[u].pop_front(); n_bad++;
          $display("FAIL timeout u%0d: no event, required kind=%0d dir=%b", u, e.kind, e.dir);
        end else begin
          e = exp_q[u].pop_front(); g = got_q[u].pop_front();
          if (g.kind !== e.kind || g.dir !== e.dir || g.scan !== e.scan) begin
            n_bad++;
            $display("FAIL timeout u%0d: kind=%0d dir=%b sc=%h, required kind=%0d dir=%b sc=%h",
                     u, g.kind, g.dir, g.scan, e.kind, e.dir, e.scan);
          end
        end
      end
    end
    n_cmp++;
    if (sc[0] !== 8'h23 || sc[1] !== 8'h23) begin
      n_bad++;
      $display("FAIL timeout_next: sc=%h %h, required 23 23", sc[0], sc[1]);
    end
  endtask

  task automatic test_glitch_and_reset();
    ev_t e, g;
    @(negedge clk);
    ps2_data = 1'b0;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (FL - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
    ps2_data = 1'b1;
    repeat (TO + 40) @(negedge clk);
    n_cmp++;
    if (got_q[0].size() != 0 || got_q[1].size() != 0) begin
      n_bad++;
      $display("FAIL glitch: %0d/%0d events after short glitch, required 0/0",
               got_q[0].size(), got_q[1].size());
    end
    got_q[0].delete();
    got_q[1].delete();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int unsigned u = 0; u < 2; u++) begin
      n_cmp++;
      if (dir[u] !== C_R || sc[u] !== 8'h00) begin
        n_bad++;
        $display("FAIL midframe_reset u%0d: dir=%b sc=%h, required 100 00", u, dir[u], sc[u]);
      end
    end
    m_dir[0] = C_R; m_dir[1] = C_R; m_brk = 1'b0; m_ext = 1'b0; m_scan = 8'h00;
    ps2_data = 1'b1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h29, 0, 1, 11);
    for (int unsigned u = 0; u < 2; u++) begin
      while (exp_q[u].size() > 0 || got_q[u].size() > 0) begin
        n_cmp++;
        if (exp_q[u].size() == 0) begin
          g = got_q[u].pop_front(); n_bad++;
          $display("FAIL reset_29 u%0d: extra event kind=%0d dir=%b, required none", u, g.kind, g.dir);
        end else if (got_q[u].size() == 0) begin
          e = exp_q[u].pop_front(); n_bad++;
          $display("FAIL reset_29 u%0d: no event, required kind=%0d dir=%b", u, e.kind, e.dir);
        end else begin
          e = exp_q[u].pop_front(); g = got_q[u].pop_front();
          if (g.kind !== e.kind || g.dir !== e.dir || g.scan !== e.scan) begin
            n_bad++;
            $display("FAIL reset_29 u%0d: kind=%0d dir=%b sc=%h, required kind=%0d dir=%b sc=%h",
                     u, g.kind, g.dir, g.scan, e.kind, e.dir, e.scan);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    ev_t e, g;
    send_frame(8'h1D, 0, 1, 11);
    send_frame(8'h1D, 0, 1, 11);
    send_frame(8'hF0, 0, 1, 11);
    send_frame(8'h1D, 0, 1, 11);
    send_frame(8'hE0, 0, 1, 11);
    send_frame(8'h72, 0, 1, 11);
    send_frame(8'h29, 0, 1, 11);
    send_frame(8'hE0, 0, 1, 11);
    send_frame(8'h74, 0, 1, 11);
    for (int unsigned u = 0; u < 2; u++) begin
      while (exp_q[u].size() > 0 || got_q[u].size() > 0) begin
        n_cmp++;
        if (exp_q[u].size() == 0) begin
          g = got_q[u].pop_front(); n_bad++;
          $display("FAIL back_to_back u%0d: extra event kind=%0d dir=%b, required none", u, g.kind, g.dir);
        end else if (got_q[u].size() == 0) begin
          e = exp_q[u].pop_front(); n_bad++;
          $display("FAIL back_to_back u%0d: no event, required kind=%0d dir=%b", u, e.kind, e.dir);
        end else begin
          e = exp_q[u].pop_front(); g = got_q[u].pop_front();
          if (g.kind !== e.kind || g.dir !== e.dir || g.scan !== e.scan) begin
            n_bad++;
            $display("FAIL back_to_back u%0d: kind=%0d dir=%b sc=%h, required kind=%0d dir=%b sc=%h",
                     u, g.kind, g.dir, g.scan, e.kind, e.dir, e.scan);
          end
        end
      end
    end
    n_cmp++;
    if (coll !== 0) begin
      n_bad++;
      $display("FAIL exclusive_pulses: %0d cycles with key_valid and frame_err together, required 0", coll);
    end
  endtask

  initial begin
    m_dir[0] = C_R;
    m_dir[1] = C_R;
    m_brk    = 1'b0;
    m_ext    = 1'b0;
    m_scan   = 8'h00;
    test_reset();
    test_make();
    test_reverse();
    test_break_ext();
    test_frame_errors();
    test_timeout();
    test_glitch_and_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
